// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse_meter stage: FSM encodings and default counter width.
package pulse_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/pulse_meter_edge_detect.sv
// edge_detect: samples a pulse train and flags rising/falling edges.
// Optional macro PULSE_METER_SYNC_EN inserts a 2-flop synchronizer ahead of the
// edge detector for asynchronous sources (adds 2 cycles of latency).
// Ports:
//   i_clock   : clock, all logic on posedge
//   i_reset   : synchronous active-high reset
//   i_sig     : pulse train input
//   o_level_c : current sample s (combinational)
//   o_rise_c  : s & ~s_q (combinational)
//   o_fall_c  : ~s & s_q (combinational)
module edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_level_c,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic w_s;
    logic r_s_q;

`ifdef PULSE_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for sources not timed to i_clock
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = i_sig;
`endif

    // Previous sample; tracks the input regardless of any downstream enable
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s_q <= 1'b0;
        end else begin
            r_s_q <= w_s;
        end
    end

    assign o_level_c = w_s;
    assign o_rise_c  = w_s & ~r_s_q;
    assign o_fall_c  = ~w_s & r_s_q;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high time and rise-to-rise period of a pulse train in
// clock cycles and reports each completed period on a valid/ready port.
// Optional macro PULSE_METER_SYNC_EN (handled in edge_detect) synchronizes pulse_in.
// Ports:
//   clock, reset            : clock and synchronous active-high reset
//   enable                  : measurement enable, low aborts a measurement
//   pulse_in                : pulse train under measurement
//   meas_width/meas_period  : last captured high time / period
//   meas_sat                : a counter saturated during the captured period
//   meas_valid/meas_ready   : result handshake
//   overrun                 : sticky, a result was dropped while one was pending
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_sat,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_level;
    logic             w_rise;
    logic             w_fall;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_width_cnt;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] w_width_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic             r_sat;
    logic             w_sat_nxt;
    logic             w_capture;

    edge_detect u_edge_detect (
        .i_clock   (clock),
        .i_reset   (reset),
        .i_sig     (pulse_in),
        .o_level_c (w_level),
        .o_rise_c  (w_rise),
        .o_fall_c  (w_fall)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and counter updates; saturation is flagged when an increment is lost
    always_comb begin
        w_state_nxt  = r_state;
        w_width_nxt  = r_width_cnt;
        w_period_nxt = r_period_cnt;
        w_sat_nxt    = r_sat;
        w_capture    = 1'b0;

        if (!enable) begin
            w_state_nxt  = ST_IDLE;
            w_width_nxt  = '0;
            w_period_nxt = '0;
            w_sat_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_width_nxt  = '0;
                    w_period_nxt = '0;
                    w_sat_nxt    = 1'b0;
                    if (w_rise) begin
                        w_width_nxt  = CNT_ONE;
                        w_period_nxt = CNT_ONE;
                        w_state_nxt  = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (r_period_cnt == CNT_MAX) begin
                        w_sat_nxt = 1'b1;
                    end else begin
                        w_period_nxt = r_period_cnt + CNT_ONE;
                    end
                    if (w_level) begin
                        if (r_width_cnt == CNT_MAX) begin
                            w_sat_nxt = 1'b1;
                        end else begin
                            w_width_nxt = r_width_cnt + CNT_ONE;
                        end
                    end
                    if (w_fall) begin
                        w_state_nxt = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        // Rise cycle closes the old period and opens the new one
                        w_capture    = 1'b1;
                        w_width_nxt  = CNT_ONE;
                        w_period_nxt = CNT_ONE;
                        w_sat_nxt    = 1'b0;
                        w_state_nxt  = ST_HIGH;
                    end else if (r_period_cnt == CNT_MAX) begin
                        w_sat_nxt = 1'b1;
                    end else begin
                        w_period_nxt = r_period_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_width_nxt  = '0;
                    w_period_nxt = '0;
                    w_sat_nxt    = 1'b0;
                end
            endcase
        end
    end

    // Counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_width_cnt  <= '0;
            r_period_cnt <= '0;
            r_sat        <= 1'b0;
        end else begin
            r_width_cnt  <= w_width_nxt;
            r_period_cnt <= w_period_nxt;
            r_sat        <= w_sat_nxt;
        end
    end

    // Result registers and handshake; a capture may coincide with a transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            meas_width  <= '0;
            meas_period <= '0;
            meas_sat    <= 1'b0;
            meas_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else if (w_capture) begin
            if (!meas_valid || meas_ready) begin
                meas_width  <= r_width_cnt;
                meas_period <= r_period_cnt;
                meas_sat    <= r_sat;
                meas_valid  <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: expected results are queued as periods are
// driven and compared when the DUT hands them over on valid/ready.
module tb_pulse_meter;

    typedef struct {
        int w;
        int p;
        bit s;
    } res_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       pulse_in;
    logic       meas_ready;

    logic [7:0] m8_width;
    logic [7:0] m8_period;
    logic       m8_sat;
    logic       m8_valid;
    logic       m8_overrun;

    logic [3:0] m4_width;
    logic [3:0] m4_period;
    logic       m4_sat;
    logic       m4_valid;
    logic       m4_overrun;

    res_t q8[$];
    res_t q4[$];
    bit   chk4 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    pulse_meter #(.CNT_W(8)) u_dut8 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .meas_width  (m8_width),
        .meas_period (m8_period),
        .meas_sat    (m8_sat),
        .meas_valid  (m8_valid),
        .meas_ready  (meas_ready),
        .overrun     (m8_overrun)
    );

    pulse_meter #(.CNT_W(4)) u_dut4 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .meas_width  (m4_width),
        .meas_period (m4_period),
        .meas_sat    (m4_sat),
        .meas_valid  (m4_valid),
        .meas_ready  (meas_ready),
        .overrun     (m4_overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v);
        pulse_in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int h, input int l);
        repeat (h) cyc(1'b1);
        repeat (l) cyc(1'b0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pulse_in = 1'b0;
        enable   = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic push8(input int w, input int p, input bit s);
        res_t e;
        e.w = w; e.p = p; e.s = s;
        q8.push_back(e);
    endtask

    task automatic push4(input int w, input int p, input bit s);
        res_t e;
        e.w = w; e.p = p; e.s = s;
        q4.push_back(e);
    endtask

    // Scoreboard for the 8-bit instance: every transfer must match the queue head
    always @(negedge clock) begin
        if (!reset && m8_valid && meas_ready) begin
            checks++;
            assert (q8.size() != 0)
            else begin
                errors++;
                $error("FAIL xfer8_unexpected observed w=%0d p=%0d expected no transfer", m8_width, m8_period);
            end
            if (q8.size() != 0) begin
                res_t e;
                e = q8.pop_front();
                checks++;
                assert (m8_width === 8'(e.w) && m8_period === 8'(e.p) && m8_sat === e.s)
                else begin
                    errors++;
                    $error("FAIL xfer8 observed w=%0d p=%0d s=%0d expected w=%0d p=%0d s=%0d",
                           m8_width, m8_period, m8_sat, e.w, e.p, e.s);
                end
            end
        end
    end

    // Scoreboard for the 4-bit instance, active only in the saturation section
    always @(negedge clock) begin
        if (chk4 && !reset && m4_valid && meas_ready) begin
            checks++;
            assert (q4.size() != 0)
            else begin
                errors++;
                $error("FAIL xfer4_unexpected observed w=%0d p=%0d expected no transfer", m4_width, m4_period);
            end
            if (q4.size() != 0) begin
                res_t e;
                e = q4.pop_front();
                checks++;
                assert (m4_width === 4'(e.w) && m4_period === 4'(e.p) && m4_sat === e.s)
                else begin
                    errors++;
                    $error("FAIL xfer4 observed w=%0d p=%0d s=%0d expected w=%0d p=%0d s=%0d",
                           m4_width, m4_period, m4_sat, e.w, e.p, e.s);
                end
            end
        end
    end

    initial begin
        meas_ready = 1'b0;
        do_reset();

        // Reset state
        check("rst_valid",   32'(m8_valid),   32'd0);
        check("rst_width",   32'(m8_width),   32'd0);
        check("rst_period",  32'(m8_period),  32'd0);
        check("rst_sat",     32'(m8_sat),     32'd0);
        check("rst_overrun", 32'(m8_overrun), 32'd0);

        // 2 high / 8 low, always ready
        meas_ready = 1'b1;
        run(2, 8);
        check("first_rise_no_result", 32'(m8_valid), 32'd0);
        repeat (4) begin
            push8(2, 10, 1'b0);
            run(2, 8);
        end
        push8(2, 10, 1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // Backpressure for 3 periods, 3 high / 5 low
        do_reset();
        meas_ready = 1'b0;
        run(3, 5);
        run(3, 5);
        check("bp_valid",        32'(m8_valid),   32'd1);
        check("bp_width",        32'(m8_width),   32'd3);
        check("bp_period",       32'(m8_period),  32'd8);
        check("bp_overrun_pre",  32'(m8_overrun), 32'd0);
        run(3, 5);
        check("bp_overrun",      32'(m8_overrun), 32'd1);
        check("bp_width_hold",   32'(m8_width),   32'd3);
        check("bp_period_hold",  32'(m8_period),  32'd8);
        run(3, 5);
        check("bp_period_hold2", 32'(m8_period),  32'd8);
        check("bp_valid_hold",   32'(m8_valid),   32'd1);
        push8(3, 8, 1'b0);
        meas_ready = 1'b1;
        cyc(1'b0);
        check("bp_valid_drop",   32'(m8_valid),   32'd0);
        repeat (2) cyc(1'b0);
        check("bp_valid_idle",   32'(m8_valid),   32'd0);
        check("bp_overrun_stky", 32'(m8_overrun), 32'd1);
        push8(3, 11, 1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // Capture coincident with a transfer
        do_reset();
        meas_ready = 1'b0;
        run(2, 3);
        run(3, 4);
        push8(2, 5, 1'b0);
        push8(3, 7, 1'b0);
        meas_ready = 1'b1;
        cyc(1'b1);
        check("coin_valid",   32'(m8_valid),   32'd1);
        check("coin_width",   32'(m8_width),   32'd3);
        check("coin_period",  32'(m8_period),  32'd7);
        check("coin_overrun", 32'(m8_overrun), 32'd0);
        repeat (3) cyc(1'b0);
        check("coin_valid_end", 32'(m8_valid), 32'd0);

        // Saturation on the 4-bit instance, 3 high / 20 low
        do_reset();
        chk4       = 1'b1;
        meas_ready = 1'b1;
        run(3, 20);
        push4(3, 15, 1'b1);
        push8(3, 23, 1'b0);
        run(3, 5);
        push4(3, 8, 1'b0);
        push8(3, 8, 1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);
        chk4 = 1'b0;
        check("sat4_overrun", 32'(m4_overrun), 32'd0);

        // Reset mid-HIGH with a pending result
        do_reset();
        meas_ready = 1'b0;
        run(2, 3);
        run(2, 3);
        cyc(1'b1);
        cyc(1'b1);
        check("prerst_valid",   32'(m8_valid),   32'd1);
        check("prerst_overrun", 32'(m8_overrun), 32'd1);
        reset = 1'b1;
        cyc(1'b1);
        reset = 1'b0;
        check("rst2_valid",   32'(m8_valid),   32'd0);
        check("rst2_width",   32'(m8_width),   32'd0);
        check("rst2_period",  32'(m8_period),  32'd0);
        check("rst2_sat",     32'(m8_sat),     32'd0);
        check("rst2_overrun", 32'(m8_overrun), 32'd0);
        meas_ready = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        run(2, 3);
        check("rst2_first_rise", 32'(m8_valid), 32'd0);
        push8(2, 5, 1'b0);
        run(2, 4);
        push8(2, 6, 1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // Enable dropped mid-LOW, pulse_in high across re-enable
        do_reset();
        meas_ready = 1'b1;
        run(2, 3);
        enable = 1'b0;
        cyc(1'b0);
        repeat (3) cyc(1'b1);
        enable = 1'b1;
        repeat (2) cyc(1'b1);
        repeat (3) cyc(1'b0);
        check("en_no_result", 32'(m8_valid), 32'd0);
        run(2, 3);
        check("en_first_rise", 32'(m8_valid), 32'd0);
        push8(2, 5, 1'b0);
        run(2, 3);
        push8(2, 5, 1'b0);
        cyc(1'b1);
        repeat (3) cyc(1'b0);

        // Every queued result must have been delivered
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Downstream consumer of the `pulse` generator stage. It samples a pulse train on the shared `clock` and measures each period's high time and full period in clock cycles. Each completed period is reported on a valid/ready result port. It is the measurement and monitor stage for pulse-producing blocks in the `Guia_09` clocking exercises.

## Interface
- `CNT_W`, default 8: width of the width and period counters and results.
- `clock` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: measurement enable. Low aborts any measurement in progress.
- `pulse_in` in 1: pulse train under measurement, e.g. `pulse.signal`.
- `meas_width` out CNT_W: high-time of the last captured period, in cycles.
- `meas_period` out CNT_W: rise-to-rise period of the last captured period, in cycles.
- `meas_sat` out 1: a counter saturated during the captured period.
- `meas_valid` out 1: result registers hold an unconsumed result.
- `meas_ready` in 1: consumer accepts the result.
- `overrun` out 1: sticky; a result was dropped because the previous one was unconsumed.

## Operation
- Sample `s` = `pulse_in` at posedge, or the synchronized version (see Configuration). `s_q` is the previous sample.
- Edge detect: `rise = s & ~s_q`, `fall = ~s & s_q`.
- FSM states:
  - IDLE: counters held at 0. On `rise`: width_cnt=1, period_cnt=1, go to HIGH.
  - HIGH: period_cnt+1 each cycle. width_cnt+1 while `s`=1. On `fall`: go to LOW.
  - LOW: period_cnt+1 each cycle. On `rise`: capture the result, set width_cnt=1 and period_cnt=1, go to HIGH.
- The rise cycle belongs to the new period. Example: 2 cycles high + 8 low gives width=2, period=10.
- Counters saturate at 2^CNT_W−1 and never wrap. Saturation sets an internal sat bit, which is reported as `meas_sat` with the captured result and cleared at the next rise.
- Capture behaviour:
  - If `meas_valid`=0, or `meas_valid`=1 and `meas_ready`=1 in the same cycle: load the result registers and set `meas_valid`=1.
  - Otherwise: drop the new result, keep the old one, and set `overrun`=1.
- Handshake:
  - Transfer occurs on a posedge with `meas_valid` & `meas_ready`.
  - `meas_valid` falls the next cycle unless a capture happens in the same cycle.
  - Result outputs are stable while `meas_valid`=1 and `meas_ready`=0.
- `enable`=0:
  - Force FSM to IDLE and clear counters; `s_q` keeps tracking.
  - Pending result and `overrun` are unaffected; the handshake keeps working.
  - On re-enable, wait for a fresh rise. A level already high is not a rise.
- Reset: FSM to IDLE. All counters, `s_q` and synchronizer flops = 0. `meas_width`, `meas_period`, `meas_sat`, `meas_valid`, `overrun` = 0.
- Reset has priority over everything, including mid-measurement and a pending result.

## Timing
- `meas_valid` rises on the posedge after the cycle in which the closing `rise` is sampled: 1 cycle latency from sample.
- With the synchronizer: +2 cycles from the `pulse_in` transition.
- Minimum measurable pulse: 1 cycle high, 1 cycle low, giving period=2, width=1.
- Continuous `s`=1 after entering HIGH: width and period saturate; no result until a later fall then rise.
- First rise after reset or enable produces no result. The first result follows the second rise.
- `overrun` clears only on `reset`.

## Configuration
- `PULSE_METER_SYNC_EN` defined: `pulse_in` passes through a 2-flop synchronizer before edge detection, for asynchronous or glitchy sources. Adds 2 cycles latency; measured values are unchanged.
- Undefined: `pulse_in` is sampled directly and must be synchronous to `clock`.

## Structure
- Shared header/package `pulse_meter_pkg`: FSM state encodings (IDLE=2'd0, HIGH=2'd1, LOW=2'd2) and default `CNT_W`.
- Sub-module `edge_detect`:
  - Contains the optional synchronizer, the `s_q` register and the `rise`/`fall` outputs.
  - Instanced once.
  - Reusable by other stages that consume `pulse`.
- Top holds the FSM, the counters, the result registers and the handshake.

## Test plan
- Pattern 2 high / 8 low repeated, `meas_ready`=1: first result after the second rise gives width=2, period=10, sat=0. Every period thereafter gives the same values.
- `meas_ready`=0 for 3 periods, pattern 3/5: first result width=3, period=8 held stable, `overrun`=1 after the next capture. Raising ready gives one transfer, then `meas_valid`=0 until the next rise.
- Capture coincident with handshake (ready=1 on the capture cycle): new result loaded, `meas_valid` stays 1, `overrun` stays 0.
- `CNT_W`=4, pattern 3 high / 20 low: width=3, period=15, `meas_sat`=1. The next normal period 3/5 gives sat=0.
- `reset` pulsed for 1 cycle while in HIGH with a pending result: all outputs 0 the next cycle. The next result needs two fresh rises.
- `enable` dropped for 4 cycles mid-LOW while `pulse_in` stays high across re-enable: no spurious result. Measurement resumes from the next genuine rise.
